// File: rtl/trivium_pkg.sv
// Shared constants and types for the Trivium keystream blocks.
//   KEY_W / IV_W / STATE_W : Trivium key, IV and internal state widths
//   INIT_STEPS_DEF         : default number of warm-up updates
//   FIFO_FULL / FIFO_EMPTY : byte FIFO condition codes
//   tsw_state_t            : writer FSM state encoding
package trivium_pkg;

  localparam int KEY_W          = 80;
  localparam int IV_W           = 80;
  localparam int STATE_W        = 288;
  localparam int INIT_STEPS_DEF = 1152;

  localparam logic [1:0] FIFO_FULL  = 2'b11;
  localparam logic [1:0] FIFO_EMPTY = 2'b00;

  typedef enum logic [1:0] {IDLE, INIT, GEN, FLUSH} tsw_state_t;

endpackage

// File: rtl/trivium_stream_writer_if.sv
// Write side of the 8-bit byte FIFO.
//   dout      : byte presented to the FIFO din
//   write     : write strobe; the FIFO captures dout on a rising edge while high
//   condition : FIFO status from the FIFO; 2'b11 = full
// modport master : the byte producer (drives dout/write)
// modport slave  : the FIFO (drives condition)
interface trivium_stream_writer_if;
  logic [7:0] dout;
  logic       write;
  logic [1:0] condition;

  modport master (output dout, output write, input condition);
  modport slave  (input dout, input write, output condition);
endinterface

// File: rtl/trivium_core.sv
// Trivium cipher state and update logic.
//   clk, rst : clock, asynchronous active-low reset
//   load     : load key/IV into the 288-bit state (takes priority over step)
//   step     : apply one Trivium update
//   key, iv  : key[i] = K(i+1), iv[i] = IV(i+1)
//   z        : keystream bit of the current state (combinational)
// State bit s[i-1] holds Trivium bit s(i).
module trivium_core
  import trivium_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic             z
);

  logic [STATE_W-1:0] s;
  logic t1, t2, t3;

  // NOTE: every variable written in always_comb is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    z  = s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
  end

  // NOTE: the wide state is a plain register, not a memory, so clearing it
  // on reset is cheap and keeps the keystream deterministic after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else if (load) begin
      // s1..s93 = K,0^13 ; s94..s177 = IV,0^4 ; s178..s288 = 0^108,1,1,1
      s <= {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
    end else if (step) begin
      // Three shift registers, each fed by the feedback of another.
      s <= {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
  end

endmodule

// File: rtl/trivium_stream_writer.sv
// Trivium keystream producer and write-side master of the byte FIFO.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : one-cycle request, honoured only in IDLE with len != 0
//   key, iv         : 80-bit key and IV, loaded with start
//   len             : number of bytes to produce, sampled with start
//   fifo (master)   : dout/write to the FIFO, condition from the FIFO
//   ready           : high in IDLE
//   done            : one-cycle pulse after the last byte has been written
// After INIT_STEPS warm-up updates one keystream bit is generated per cycle
// and packed LSB-first into bytes; generation pauses while a byte is waiting
// on a full FIFO.
module trivium_stream_writer
  import trivium_pkg::*;
#(
  parameter int INIT_STEPS = INIT_STEPS_DEF,
  parameter int LEN_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KEY_W-1:0]       key,
  input  logic [IV_W-1:0]        iv,
  input  logic [LEN_W-1:0]       len,
  trivium_stream_writer_if.master fifo,
  output logic                   ready,
  output logic                   done
);

  localparam logic [10:0] LAST_STEP = 11'(INIT_STEPS - 1);

  tsw_state_t       state;
  logic [10:0]      step_cnt;
  logic [LEN_W-1:0] bytes_left;
  logic [2:0]       bit_cnt;
  logic [6:0]       sh;        // the last seven keystream bits, oldest in sh[0]
  logic [7:0]       dout_q;
  logic             pending;

  logic z, load, step, fifo_ok, wr, gen_en;

  assign fifo_ok = (fifo.condition != FIFO_FULL);
  assign wr      = pending && fifo_ok;
  // A waiting byte only blocks generation while the FIFO is full; otherwise
  // it leaves at this edge and a new byte may replace it at the same edge.
  assign gen_en  = !pending || fifo_ok;
  assign load    = (state == IDLE) && start && (len != '0);
  assign step    = (state == INIT) || ((state == GEN) && gen_en);

  assign fifo.write = wr;
  assign fifo.dout  = dout_q;
  assign ready      = (state == IDLE);

  trivium_core u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .key  (key),
    .iv   (iv),
    .z    (z)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block override earlier
  // defaults (pending, done).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step_cnt   <= '0;
      bytes_left <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      dout_q     <= '0;
      pending    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr) pending <= 1'b0;

      case (state)
        IDLE: begin
          if (load) begin
            bytes_left <= len;
            step_cnt   <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            state      <= INIT;
          end
        end

        INIT: begin
          step_cnt <= step_cnt + 11'd1;
          if (step_cnt == LAST_STEP) state <= GEN;
        end

        GEN: begin
          if (gen_en) begin
            sh      <= {z, sh[6:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              dout_q  <= {z, sh};
              pending <= 1'b1;
              if (bytes_left != '0) bytes_left <= bytes_left - 1'b1;
              if (bytes_left == LEN_W'(1)) state <= FLUSH;
            end
          end
        end

        FLUSH: begin
          // Last byte goes out, then done for one cycle, then back to IDLE.
          if (done)    state <= IDLE;
          else if (wr) done  <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_stream_writer.sv
module tb_trivium_stream_writer;
  import trivium_pkg::*;

  localparam int IA = 1152;  // full warm-up instance
  localparam int IB = 4;     // short warm-up instance

  typedef struct {
    logic [7:0] data;
    int         cyc;   // expected edge count at the write sample, -1 = untimed
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [79:0] key = '0, iv = '0;
  logic [15:0] len = '0;
  logic        ready_a, done_a, ready_b, done_b;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  exp_t        q_a[$], q_b[$];
  logic [7:0]  mb[32];

  trivium_stream_writer_if fifo_a ();
  trivium_stream_writer_if fifo_b ();

  trivium_stream_writer #(.INIT_STEPS(IA), .LEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key(key), .iv(iv), .len(len),
    .fifo(fifo_a.master), .ready(ready_a), .done(done_a));

  trivium_stream_writer #(.INIT_STEPS(IB), .LEN_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key(key), .iv(iv), .len(len),
    .fifo(fifo_b.master), .ready(ready_b), .done(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Trivium reference with spec-level 1-based bit numbering.
  function automatic void run_model(input logic [79:0] k, input logic [79:0] v,
                                    input int steps, input int n);
    bit s[1:288];
    bit t1, t2, t3, z;
    int j;
    for (int i = 0; i < 32; i++) mb[i] = '0;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int st = 0; st < steps + 8 * n; st++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
      if (st >= steps) begin
        j = st - steps;
        mb[j / 8][j % 8] = z;
      end
    end
  endfunction

  function automatic void push_exp(input bit b, input int n, input int e0,
                                   input int steps, input int stall, input bit timed);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.data = mb[k-1];
      e.cyc  = timed ? e0 + steps + 8 * k + stall : -1;
      if (b) q_b.push_back(e); else q_a.push_back(e);
    end
  endfunction

  // Scoreboard monitors: every write pops one expected byte.
  always begin : mon_a
    exp_t e;
    @(negedge clk); #1;
    if (fifo_a.write === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_write", fifo_a.dout, 8'hxx);
      else begin
        e = q_a.pop_front();
        check("a_byte", fifo_a.dout, e.data);
        if (e.cyc >= 0) check("a_write_cycle", cyc, e.cyc);
      end
    end
  end

  always begin : mon_b
    exp_t e;
    @(negedge clk); #1;
    if (fifo_b.write === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_write", fifo_b.dout, 8'hxx);
      else begin
        e = q_b.pop_front();
        check("b_byte", fifo_b.dout, e.data);
        if (e.cyc >= 0) check("b_write_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_start(input bit b, input logic [15:0] l, output int e0);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    len = l;
    e0  = cyc + 1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int budget, input bit rnd_cond, output int dc);
    bit seen = 1'b0;
    dc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rnd_cond) begin
        if (b) fifo_b.condition = 2'($urandom_range(0, 3));
        else   fifo_a.condition = 2'($urandom_range(0, 3));
      end
      #1;
      if ((b ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    check(b ? "b_done_seen" : "a_done_seen", seen, 1'b1);
    fifo_a.condition = 2'b01; fifo_b.condition = 2'b01;
  endtask

  task automatic check_idle_after(input bit b);
    @(negedge clk); #1;
    check(b ? "b_ready_after_done" : "a_ready_after_done", b ? ready_b : ready_a, 1'b1);
    check(b ? "b_done_one_cycle" : "a_done_one_cycle", b ? done_b : done_a, 1'b0);
    check(b ? "b_queue_empty" : "a_queue_empty", b ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin : stim
    int e0, dc, n;
    fifo_a.condition = 2'b01;
    fifo_b.condition = 2'b01;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_ready", ready_a, 1'b1);
    check("rst_write", fifo_a.write, 1'b0);
    check("rst_dout", fifo_a.dout, 8'h00);
    check("rst_done", done_a, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Known answer: key=0 iv=0 len=4, FIFO never full
    key = '0; iv = '0;
    run_model(key, iv, IA, 4);
    do_start(0, 16'd4, e0);
    push_exp(0, 4, e0, IA, 0, 1'b1);
    wait_done(0, IA + 100, 1'b0, dc);
    check("kat_done_cycle", dc, e0 + IA + 33);
    check_idle_after(0);

    // Backpressure: full for 20 cycles once the first byte is pending
    do_start(0, 16'd4, e0);
    push_exp(0, 4, e0, IA, 20, 1'b1);
    repeat (IA + 7) @(negedge clk);
    fifo_a.condition = FIFO_FULL;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("stall_write_low", fifo_a.write, 1'b0);
      check("stall_dout_held", fifo_a.dout, mb[0]);
    end
    @(negedge clk);
    fifo_a.condition = 2'b10;
    wait_done(0, IA + 100, 1'b0, dc);
    check("stall_done_cycle", dc, e0 + IA + 33 + 20);
    check_idle_after(0);

    // start with len=0 is ignored
    do_start(0, 16'd0, e0);
    repeat (10) @(negedge clk);
    #1 check("len0_stays_idle", ready_a, 1'b1);

    // start during INIT is ignored
    key = {$urandom, $urandom, 16'($urandom)};
    iv  = {$urandom, $urandom, 16'($urandom)};
    run_model(key, iv, IA, 3);
    do_start(0, 16'd3, e0);
    push_exp(0, 3, e0, IA, 0, 1'b1);
    repeat (100) @(negedge clk);
    #1 check("init_not_ready", ready_a, 1'b0);
    key = ~key;
    do_start(0, 16'd7, n);
    wait_done(0, IA + 100, 1'b0, dc);
    check("init_restart_done_cycle", dc, e0 + IA + 25);
    check_idle_after(0);

    // Random key/iv/len with random FIFO full, full warm-up
    key = {$urandom, $urandom, 16'($urandom)};
    iv  = {$urandom, $urandom, 16'($urandom)};
    n   = $urandom_range(1, 5);
    run_model(key, iv, IA, n);
    do_start(0, 16'(n), e0);
    push_exp(0, n, e0, IA, 0, 1'b0);
    wait_done(0, IA + 400, 1'b1, dc);
    check_idle_after(0);

    // Short init: key=1 iv=0 len=2, then back-to-back rerun
    key = 80'h1; iv = '0;
    run_model(key, iv, IB, 2);
    do_start(1, 16'd2, e0);
    push_exp(1, 2, e0, IB, 0, 1'b1);
    wait_done(1, 100, 1'b0, dc);
    check("short_done_cycle", dc, e0 + IB + 17);
    @(negedge clk);
    start_b = 1'b1; len = 16'd2; e0 = cyc + 1;
    push_exp(1, 2, e0, IB, 0, 1'b1);
    #1 check("rerun_ready", ready_b, 1'b1);
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1, 100, 1'b0, dc);
    check("rerun_done_cycle", dc, e0 + IB + 17);
    check_idle_after(1);

    // Random short-init runs with random FIFO full
    for (int r = 0; r < 6; r++) begin
      key = {$urandom, $urandom, 16'($urandom)};
      iv  = {$urandom, $urandom, 16'($urandom)};
      n   = $urandom_range(1, 8);
      run_model(key, iv, IB, n);
      do_start(1, 16'(n), e0);
      push_exp(1, n, e0, IB, 0, 1'b0);
      wait_done(1, 400, 1'b1, dc);
      check_idle_after(1);
    end

    // Asynchronous reset while a byte is being written in GEN
    key = 80'h1; iv = '0;
    run_model(key, iv, IB, 2);
    do_start(1, 16'd2, e0);
    push_exp(1, 2, e0, IB, 0, 1'b1);
    repeat (IB + 8) @(negedge clk);
    #2;
    check("pre_reset_write", fifo_b.write, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_write", fifo_b.write, 1'b0);
    check("async_rst_dout", fifo_b.dout, 8'h00);
    check("async_rst_ready", ready_b, 1'b1);
    check("async_rst_done", done_b, 1'b0);
    q_b.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_held_no_write", fifo_b.write, 1'b0);
    end
    rst = 1'b1;
    repeat (12) @(negedge clk);
    #1 check("post_reset_idle", ready_b, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
